// File: rtl/lockstep_tcdm_responder.sv
// TCDM bank responder for a primary/shadow core pair: round-robin arbitration when
// independent, paired single-issue with divergence detection when running in lockstep.
module lockstep_tcdm_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lockstep_mode,
  input  logic                  a_req_i,
  input  logic [ADDR_WIDTH-1:0] a_add_i,
  input  logic                  a_wen_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic [BE_WIDTH-1:0]   a_be_i,
  output logic                  a_gnt_o,
  output logic                  a_r_valid_o,
  output logic [DATA_WIDTH-1:0] a_r_rdata_o,
  input  logic                  b_req_i,
  input  logic [ADDR_WIDTH-1:0] b_add_i,
  input  logic                  b_wen_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  input  logic [BE_WIDTH-1:0]   b_be_i,
  output logic                  b_gnt_o,
  output logic                  b_r_valid_o,
  output logic [DATA_WIDTH-1:0] b_r_rdata_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  output logic                  mem_wen_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mismatch_o,
  output logic                  desync_o,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt_o,
  output logic [CNT_WIDTH-1:0]  desync_cnt_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 2);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_HOLD = TO_W'(TIMEOUT + 1);

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

  typedef struct packed {
    logic valid;
    logic dest_a;
    logic dest_b;
  } rsp_t;

  rr_e                   rr_q, rr_d;
  logic [TO_W-1:0]       to_q, to_d;
  rsp_t                  pipe_q [MEM_LATENCY];
  rsp_t                  rsp_out;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [CNT_WIDTH-1:0]  mm_cnt_q, ds_cnt_q;

  logic req_raw, fwd_a, fwd_b, use_b, desync_raw, xfer, lone, pair_diff;

  assign lone = a_req_i ^ b_req_i;

  // Lone lockstep requests are held back until the timeout counter reaches TIMEOUT;
  // past that the counter parks at TIMEOUT+1 so desync pulses only once per request.
  always_comb begin
    req_raw    = 1'b0;
    fwd_a      = 1'b0;
    fwd_b      = 1'b0;
    desync_raw = 1'b0;
    if (lockstep_mode) begin
      if (a_req_i && b_req_i) begin
        req_raw = 1'b1;
        fwd_a   = 1'b1;
        fwd_b   = 1'b1;
      end else if (lone && (to_q >= TO_LIM)) begin
        req_raw    = 1'b1;
        fwd_a      = a_req_i;
        fwd_b      = b_req_i;
        desync_raw = (to_q == TO_LIM);
      end
    end else begin
      req_raw = a_req_i | b_req_i;
      if (a_req_i && (!b_req_i || (rr_q == RR_A))) begin
        fwd_a = 1'b1;
      end else if (b_req_i) begin
        fwd_b = 1'b1;
      end
    end
  end

  assign use_b       = fwd_b & ~fwd_a;
  assign mem_req_o   = rst_ni & req_raw;
  assign mem_add_o   = use_b ? b_add_i   : a_add_i;
  assign mem_wen_o   = use_b ? b_wen_i   : a_wen_i;
  assign mem_wdata_o = use_b ? b_wdata_i : a_wdata_i;
  assign mem_be_o    = use_b ? b_be_i    : a_be_i;

  assign xfer    = mem_req_o & mem_gnt_i;
  assign a_gnt_o = xfer & fwd_a;
  assign b_gnt_o = xfer & fwd_b;

  assign pair_diff = (a_add_i != b_add_i) || (a_wen_i != b_wen_i) || (a_be_i != b_be_i) ||
                     (!a_wen_i && (a_wdata_i != b_wdata_i));

  assign mismatch_o = xfer & lockstep_mode & fwd_a & fwd_b & pair_diff;
  assign desync_o   = rst_ni & desync_raw;

  always_comb begin
    to_d = '0;
    rr_d = rr_q;
    if (lockstep_mode && lone && !xfer) begin
      to_d = (to_q >= TO_LIM) ? TO_HOLD : to_q + 1'b1;
    end
    if (!lockstep_mode && a_req_i && b_req_i && xfer) begin
      rr_d = (rr_q == RR_A) ? RR_B : RR_A;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= RR_A;
      to_q     <= '0;
      mm_cnt_q <= '0;
      ds_cnt_q <= '0;
    end else begin
      rr_q <= rr_d;
      to_q <= to_d;
      if (mismatch_o && (mm_cnt_q != '1)) mm_cnt_q <= mm_cnt_q + 1'b1;
      if (desync_o && (ds_cnt_q != '1))   ds_cnt_q <= ds_cnt_q + 1'b1;
    end
  end

  assign mismatch_cnt_o = mm_cnt_q;
  assign desync_cnt_o   = ds_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < MEM_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= rsp_t'{valid: xfer, dest_a: a_gnt_o, dest_b: b_gnt_o};
      for (int unsigned k = 1; k < MEM_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign rsp_out     = pipe_q[MEM_LATENCY-1];
  assign a_r_valid_o = rsp_out.valid & rsp_out.dest_a;
  assign b_r_valid_o = rsp_out.valid & rsp_out.dest_b;
  assign a_r_rdata_o = a_r_valid_o ? mem_rdata_i : a_rdata_q;
  assign b_r_rdata_o = b_r_valid_o ? mem_rdata_i : b_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_r_valid_o) a_rdata_q <= mem_rdata_i;
      if (b_r_valid_o) b_rdata_q <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_lockstep_tcdm_responder.sv
// Directed bench for lockstep_tcdm_responder: the driver checks grants and pushes expected
// responses; an independent monitor pops and checks them whenever r_valid appears.
module tb_lockstep_tcdm_responder;

  localparam int LAT = 2;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lockstep_mode;
  logic        a_req, b_req, a_wen, b_wen;
  logic [31:0] a_add, b_add, a_wdata, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_gnt, b_gnt, a_rv, b_rv;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_req, mem_gnt, mem_wen;
  logic [31:0] mem_add, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mismatch, desync;
  logic [7:0]  mm_cnt, ds_cnt;

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = 32'hDEADBEEF ^ 32'(cyc);

  lockstep_tcdm_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .TIMEOUT(TO), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .lockstep_mode(lockstep_mode),
    .a_req_i(a_req), .a_add_i(a_add), .a_wen_i(a_wen), .a_wdata_i(a_wdata), .a_be_i(a_be),
    .a_gnt_o(a_gnt), .a_r_valid_o(a_rv), .a_r_rdata_o(a_rdata),
    .b_req_i(b_req), .b_add_i(b_add), .b_wen_i(b_wen), .b_wdata_i(b_wdata), .b_be_i(b_be),
    .b_gnt_o(b_gnt), .b_r_valid_o(b_rv), .b_r_rdata_o(b_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .mismatch_o(mismatch), .desync_o(desync), .mismatch_cnt_o(mm_cnt), .desync_cnt_o(ds_cnt)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        qa[$], qb[$];
  exp_t        ea, eb;
  logic [31:0] last_b = '0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit to_a, input bit to_b);
    exp_t e;
    e.due  = cyc + LAT;
    e.data = 32'hDEADBEEF ^ 32'(cyc + LAT);
    if (to_a) qa.push_back(e);
    if (to_b) qb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic r, input logic [31:0] ad, input logic we, input logic [31:0] wd);
    a_req = r; a_add = ad; a_wen = we; a_wdata = wd; a_be = 4'hF;
  endtask

  task automatic drive_b(input logic r, input logic [31:0] ad, input logic we, input logic [31:0] wd);
    b_req = r; b_add = ad; b_wen = we; b_wdata = wd; b_be = 4'hF;
  endtask

  task automatic idle();
    drive_a(1'b0, '0, 1'b1, '0);
    drive_b(1'b0, '0, 1'b1, '0);
  endtask

  // Response monitor: every r_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_rv) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_rsp: got r_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_rsp_cycle", 32'(cyc), 32'(ea.due));
        chk("a_rsp_data", a_rdata, ea.data);
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL a_missing_rsp: got r_valid=0 expected 1 (cycle %0d)", cyc);
      void'(qa.pop_front());
    end
    if (b_rv) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_rsp: got r_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_rsp_cycle", 32'(cyc), 32'(eb.due));
        chk("b_rsp_data", b_rdata, eb.data);
        last_b = eb.data;
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL b_missing_rsp: got r_valid=0 expected 1 (cycle %0d)", cyc);
      void'(qb.pop_front());
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    lockstep_mode = 1'b0;
    mem_gnt = 1'b1;
    idle();
    drive_a(1'b1, 32'h10, 1'b1, '0);
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_a_rv", 32'(a_rv), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_desync", 32'(desync), 0);
    chk("rst_mm_cnt", 32'(mm_cnt), 0);
    chk("rst_ds_cnt", 32'(ds_cnt), 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Independent mode, both reading every cycle: A, B, A, ... (7 grants leaves RR on B)
    drive_a(1'b1, 32'h1000, 1'b1, '0);
    drive_b(1'b1, 32'h2000, 1'b1, '0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("rr_a_gnt", 32'(a_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_b_gnt", 32'(b_gnt), (i % 2 == 0) ? 0 : 1);
      chk("rr_mem_add", mem_add, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      push(i % 2 == 0, i % 2 != 0);
      tick();
    end
    idle();
    repeat (4) tick();

    // Bank stalls for 3 cycles with A requesting
    drive_a(1'b1, 32'h3000, 1'b1, '0);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mem_req", 32'(mem_req), 1);
      chk("stall_a_gnt", 32'(a_gnt), 0);
      chk("stall_mem_add", mem_add, 32'h3000);
      tick();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("stall_release_gnt", 32'(a_gnt), 1);
    push(1'b1, 1'b0);
    tick();
    idle();
    repeat (4) tick();

    // Lockstep identical read; differing wdata must be ignored on reads
    lockstep_mode = 1'b1;
    drive_a(1'b1, 32'h100, 1'b1, 32'h55);
    drive_b(1'b1, 32'h100, 1'b1, 32'hAA);
    @(negedge clk);
    chk("ls_rd_a_gnt", 32'(a_gnt), 1);
    chk("ls_rd_b_gnt", 32'(b_gnt), 1);
    chk("ls_rd_mem_add", mem_add, 32'h100);
    chk("ls_rd_mismatch", 32'(mismatch), 0);
    push(1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("ls_rd_single_xfer", 32'(mem_req), 0);
    chk("ls_rd_mm_cnt", 32'(mm_cnt), 0);
    repeat (4) tick();

    // Lockstep write with diverging wdata: A's data wins, one mismatch
    drive_a(1'b1, 32'h40, 1'b0, 32'h1);
    drive_b(1'b1, 32'h40, 1'b0, 32'h2);
    @(negedge clk);
    chk("ls_wr_a_gnt", 32'(a_gnt), 1);
    chk("ls_wr_b_gnt", 32'(b_gnt), 1);
    chk("ls_wr_mem_wen", 32'(mem_wen), 0);
    chk("ls_wr_mem_wdata", mem_wdata, 32'h1);
    chk("ls_wr_mismatch", 32'(mismatch), 1);
    push(1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("ls_wr_mismatch_once", 32'(mismatch), 0);
    chk("ls_wr_mm_cnt", 32'(mm_cnt), 1);
    repeat (4) tick();

    // Lockstep lone A: held TIMEOUT cycles, then desync and forwarded alone
    drive_a(1'b1, 32'h80, 1'b1, '0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_wait_gnt", 32'(a_gnt), 0);
      chk("to_wait_mem_req", 32'(mem_req), 0);
      chk("to_wait_desync", 32'(desync), 0);
      tick();
    end
    @(negedge clk);
    chk("to_desync", 32'(desync), 1);
    chk("to_a_gnt", 32'(a_gnt), 1);
    chk("to_b_gnt", 32'(b_gnt), 0);
    chk("to_mem_add", mem_add, 32'h80);
    push(1'b1, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("to_desync_once", 32'(desync), 0);
    chk("to_ds_cnt", 32'(ds_cnt), 1);
    tick();
    @(negedge clk);
    chk("to_b_no_rsp", 32'(b_rv), 0);
    chk("to_b_rdata_held", b_rdata, last_b);
    repeat (4) tick();

    // Two responses in flight when reset hits; RR is on B beforehand
    lockstep_mode = 1'b0;
    drive_a(1'b1, 32'h500, 1'b1, '0);
    drive_b(1'b1, 32'h600, 1'b1, '0);
    @(negedge clk);
    chk("pre_rst_b_gnt", 32'(b_gnt), 1);
    chk("pre_rst_a_gnt", 32'(a_gnt), 0);
    tick();
    @(negedge clk);
    chk("pre_rst_a_gnt2", 32'(a_gnt), 1);
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("in_rst_a_rv", 32'(a_rv), 0);
    chk("in_rst_b_rv", 32'(b_rv), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_a_rv", 32'(a_rv), 0);
      chk("post_rst_b_rv", 32'(b_rv), 0);
      tick();
    end
    chk("post_rst_mm_cnt", 32'(mm_cnt), 0);
    chk("post_rst_ds_cnt", 32'(ds_cnt), 0);
    drive_a(1'b1, 32'h700, 1'b1, '0);
    drive_b(1'b1, 32'h800, 1'b1, '0);
    @(negedge clk);
    chk("post_rst_rr_a", 32'(a_gnt), 1);
    push(1'b1, 1'b0);
    tick();
    idle();
    repeat (4) tick();

    // 300 back-to-back mismatching lockstep writes: counter saturates at 255
    lockstep_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_a(1'b1, 32'h40, 1'b0, 32'(i));
      drive_b(1'b1, 32'h40, 1'b0, ~32'(i));
      @(negedge clk);
      chk("sat_mismatch", 32'(mismatch), 1);
      if (i == 254 || i == 255 || i == 299) chk("sat_mm_cnt", 32'(mm_cnt), (i < 255) ? i : 255);
      push(1'b1, 1'b1);
      tick();
    end
    idle();
    @(negedge clk);
    chk("sat_mm_cnt_final", 32'(mm_cnt), 255);
    repeat (6) tick();

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lockstep_tcdm_responder.md
Name: lockstep_tcdm_responder

Overview:
- Memory-side TCDM responder serving two core-side request ports: A (primary) and B (shadow).
- Fronts one SRAM bank with a fixed read latency.
- Non-lockstep mode: A and B are independent initiators, arbitrated round-robin.
- Lockstep mode: A and B must issue identical requests. The block services each pair once, returns one response to both ports, and flags divergence (request mismatch, or one port requesting alone past a timeout).

Parameters:
ADDR_WIDTH  32  TCDM address width
DATA_WIDTH  32  data width
BE_WIDTH  DATA_WIDTH/8  byte-enable width
MEM_LATENCY  1  cycles from accepted mem_req_o to mem_rdata_i valid; legal range 1..4
TIMEOUT  16  cycles a lone lockstep request waits before desync handling
CNT_WIDTH  8  width of saturating error counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lockstep_mode  in  1  1 = paired/compare mode, 0 = independent round-robin
a_req_i / b_req_i  in  1  request
a_add_i / b_add_i  in  ADDR_WIDTH  address
a_wen_i / b_wen_i  in  1  1 = read, 0 = write
a_wdata_i / b_wdata_i  in  DATA_WIDTH  write data
a_be_i / b_be_i  in  BE_WIDTH  byte enables
a_gnt_o / b_gnt_o  out  1  grant, combinational, same cycle as req
a_r_valid_o / b_r_valid_o  out  1  response valid
a_r_rdata_o / b_r_rdata_o  out  DATA_WIDTH  response data
mem_req_o  out  1  bank request
mem_gnt_i  in  1  bank accepts this cycle
mem_add_o  out  ADDR_WIDTH  bank address
mem_wen_o  out  1  1 = read
mem_wdata_o  out  DATA_WIDTH  bank write data
mem_be_o  out  BE_WIDTH  bank byte enables
mem_rdata_i  in  DATA_WIDTH  bank read data, valid MEM_LATENCY cycles after accepted request
mismatch_o  out  1  one-cycle pulse: lockstep pair fields differed
desync_o  out  1  one-cycle pulse: lockstep timeout expired
mismatch_cnt_o  out  CNT_WIDTH  saturating mismatch count
desync_cnt_o  out  CNT_WIDTH  saturating desync count

Behaviour:
Reset:
- All gnt, r_valid, mismatch_o, desync_o and mem_req_o are 0.
- All rdata outputs are 0; counters are 0; round-robin pointer selects A; timeout counter is 0; response pipeline is empty.
- Reset mid-operation discards in-flight responses; no r_valid is issued for them after reset release.

Accept rule:
- A transfer occurs in cycle t when mem_req_o & mem_gnt_i.
- The selected port gnt is asserted only in that cycle. mem_req_o may drop or change without a grant.

Non-lockstep arbitration:
- If exactly one port requests, it is selected.
- If both request, the port indicated by the RR pointer is selected.
- The pointer moves to the other port only on a transfer where both requested.
- mem_* outputs mirror the selected port's fields.

Lockstep arbitration:
- Both ports requesting: mem_req_o = 1 with A's fields. On transfer, a_gnt_o and b_gnt_o are both 1.
- Compare add, wen, be, and wdata; wdata is compared only when wen = 0.
- Any difference on a transfer pulses mismatch_o in that same cycle and increments mismatch_cnt_o. A's request is still performed.
- Exactly one port requesting: mem_req_o = 0 and the timeout counter increments each cycle.
- Timeout expiry: when the counter reaches TIMEOUT, desync_o pulses and desync_cnt_o increments. From that cycle the lone request is forwarded alone (mem_req_o = 1, that port's fields) until transferred, then the counter clears.
- The timeout counter clears on any transfer, on no-request cycles, and whenever lockstep_mode = 0.

Response pipeline:
- A MEM_LATENCY-deep shift register of {valid, dest_a, dest_b} is loaded on each transfer.
- At the pipeline output, r_valid is asserted on the flagged ports and their rdata = mem_rdata_i.
- Response timing: r_valid goes high at t + MEM_LATENCY for both reads and writes. Write responses carry don't-care rdata, driven as mem_rdata_i.
- Non-flagged ports hold r_valid = 0 and keep their previous rdata.
- Back-to-back transfers every cycle are supported; there is no stall.
- lockstep_mode may change any cycle. The change affects arbitration from that cycle; in-flight responses route by their stored dest flags.

Counters:
- Saturate at 2^CNT_WIDTH-1 and clear only on reset.

Test Plan:
- Non-lockstep, A and B both read every cycle, mem_gnt_i = 1, MEM_LATENCY = 1 -> grants alternate A, B, A, B starting with A. Each r_valid occurs exactly 1 cycle after its gnt with that port's data only.
- Non-lockstep, mem_gnt_i = 0 for 3 cycles with A requesting -> no gnt, mem_req_o held 1 with A's fields. Grant arrives in the cycle mem_gnt_i rises.
- Lockstep, identical read at 0x100 on both ports, MEM_LATENCY = 2, mem_rdata_i = 0xDEADBEEF -> both gnt in the same cycle, one mem transfer, both r_valid 2 cycles later with 0xDEADBEEF. mismatch_o stays 0.
- Lockstep, writes to 0x40 with wdata A = 0x1, B = 0x2 -> both granted, memory written with 0x1, mismatch_o pulses once, mismatch_cnt_o = 1.
- Lockstep, A alone requests with TIMEOUT = 16 -> no gnt for 16 cycles, then desync_o pulses, A granted alone, desync_cnt_o = 1. Only a_r_valid_o responds.
- Reset asserted while 2 responses are in flight, plus 300 forced mismatches -> no r_valid after reset release. In the mismatch run, mismatch_cnt_o saturates at 255.
